ctr_seg_display: RTL
====================

// Module: ctr_seg_display
// PURPOSE
//  Downstream consumer of the 4-bit mod-16 counter value.
//  - Registers the incoming count and splits it into decimal tens/ones digits.
//  - Drives a 2-digit time-multiplexed seven-segment display.
//  - Detects counter wrap-around (F->0): single-cycle pulse plus a wrap tally.
//  - Sits between the counter and board pins / top-level display logic.
// PARAMETERS
//  REFRESH_DIV   4   clock cycles each digit stays selected; legal range >=1
//  COMMON_ANODE  0   0: seg/an active-high; 1: seg/an active-low (all bits inverted)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous reset, active-high
//  count       in   4  counter value, sampled every cycle
//  seg         out  7  segments {g,f,e,d,c,b,a}, seg[0]=a, registered
//  an          out  2  digit enable, one-hot: an[0]=ones, an[1]=tens, registered
//  wrap_pulse  out  1  high exactly one cycle per detected F->0 transition
//  wrap_cnt    out  8  number of wraps since reset, modulo 256
// BEHAVIOUR
//  - One clock, one synchronous active-high reset; no other clock or reset.
//  - Reset values (logical, before COMMON_ANODE inversion):
//    seg=7'h00, an=2'b00, wrap_pulse=0, wrap_cnt=0; internal regs cleared, prime=0.
//  - Capture: count_q<=count every cycle; prev_q<=count_q; prime set 1 cycle after reset release.
//  - Convert (registered): tens_q=(count_q>=10); ones_q=count_q-(tens_q?10:0).
//    Latency: count sampled at edge N -> digit regs at N+1 -> seg at N+2 if digit selected.
//  - Refresh: rcnt counts 0..REFRESH_DIV-1; at terminal, rcnt->0 and dsel toggles.
//    dsel reset 0 (ones); first post-reset cycle has an=2'b01.
//  - Output regs: dsel=0 -> an=2'b01, seg=enc(ones_q); dsel=1 -> an=2'b10, seg=enc(tens_q).
//    an and seg update on the same edge.
//  - enc: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; other=00 (blank).
//  - Wrap detect: prime && prev_q==4'hF && count_q==4'h0 -> wrap_pulse=1 next cycle;
//    wrap_cnt increments on the same edge.
//  - Boundaries:
//    - wrap_cnt rolls 255->0, no saturation.
//    - A non-wrap jump from F (e.g. F->3) gives no pulse.
//    - count held at 0 gives no repeat pulse.
//    - The first 0 after reset never pulses (prime gate).
//  - Reset mid-operation: next edge with rst=1 forces all reset values, clears rcnt/dsel/wrap_cnt.
//    Operation restarts cleanly on release.
//  - COMMON_ANODE=1 inverts seg and an bitwise, including reset values (seg=7'h7F, an=2'b11).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//    defined: when dsel=1 and tens_q=0, seg=blank (7'h00 logical); an still 2'b10.
//    undefined: tens digit 0 displays 7'h3F.
//  Wrap logic and ones digit are unaffected by the macro.
// TESTING
//  1 rst=1 for 3 cycles, any count -> seg=00, an=00, wrap_pulse=0, wrap_cnt=0
//    (COMMON_ANODE=1: seg=7F, an=11).
//  2 count=7 held, REFRESH_DIV=4 -> an toggles 01/10 every 4 cycles;
//    seg=07 when an=01; seg=3F when an=10 (00 with LEADING_ZERO_BLANK_EN).
//  3 count=13 held -> seg=4F when an=01, seg=06 when an=10;
//    count 13->9 reaches seg 2 cycles after the sample edge.
//  4 count incremented 0..15 twice, then 0, from reset -> exactly two 1-cycle wrap_pulse,
//    wrap_cnt=2, no pulse at the first post-reset 0.
//  5 count F->3, then F held 5 cycles, then F->0 -> pulse only on F->0, wrap_cnt +1;
//    force 256 wraps -> wrap_cnt=0.
//  6 rst asserted mid-refresh (rcnt=2, count=9, wrap_cnt=5) -> next edge all reset values;
//    after release an=01 first, full REFRESH_DIV period.

Source files
------------

// File: rtl/ctr_seg_display.sv
// Registers a 4-bit mod-16 count, drives a 2-digit multiplexed seven-segment display
// and tallies F->0 wraps. Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module ctr_seg_display #(
   parameter int unsigned REFRESH_DIV  = 4,
   parameter bit          COMMON_ANODE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       wrap_pulse,
   output logic [7:0] wrap_cnt
);

   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] RTerm = RW'(REFRESH_DIV - 1);
   // Physical polarity masks; reset values are stored already inverted.
   localparam logic [6:0] SegInv = COMMON_ANODE ? 7'h7F : 7'h00;
   localparam logic [1:0] AnInv  = COMMON_ANODE ? 2'b11 : 2'b00;

   logic [3:0]    count_q, count_d;
   logic [3:0]    prev_q, prev_d;
   logic          prime_q, prime_d;
   logic          tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          dsel_q, dsel_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          wrap_pulse_q, wrap_pulse_d;
   logic [7:0]    wrap_cnt_q, wrap_cnt_d;
   logic [6:0]    seg_l;
   logic [1:0]    an_l;
   logic          wrap_hit;

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   always_comb begin
      count_d = count;
      prev_d  = count_q;
      prime_d = 1'b1;

      tens_d = (count_q >= 4'd10);
      ones_d = tens_d ? (count_q - 4'd10) : count_q;

      if (rcnt_q == RTerm) begin
         rcnt_d = '0;
         dsel_d = ~dsel_q;
      end else begin
         rcnt_d = rcnt_q + 1'b1;
         dsel_d = dsel_q;
      end

      if (dsel_q) begin
         an_l  = 2'b10;
         seg_l = enc({3'b000, tens_q});
`ifdef LEADING_ZERO_BLANK_EN
         if (!tens_q) seg_l = 7'h00;
`endif
      end else begin
         an_l  = 2'b01;
         seg_l = enc(ones_q);
      end
      seg_d = seg_l ^ SegInv;
      an_d  = an_l ^ AnInv;

      wrap_hit     = prime_q && (prev_q == 4'hF) && (count_q == 4'h0);
      wrap_pulse_d = wrap_hit;
      wrap_cnt_d   = wrap_cnt_q + {7'd0, wrap_hit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= 4'h0;
         prev_q       <= 4'h0;
         prime_q      <= 1'b0;
         tens_q       <= 1'b0;
         ones_q       <= 4'h0;
         rcnt_q       <= '0;
         dsel_q       <= 1'b0;
         seg_q        <= SegInv;
         an_q         <= AnInv;
         wrap_pulse_q <= 1'b0;
         wrap_cnt_q   <= 8'h00;
      end else begin
         count_q      <= count_d;
         prev_q       <= prev_d;
         prime_q      <= prime_d;
         tens_q       <= tens_d;
         ones_q       <= ones_d;
         rcnt_q       <= rcnt_d;
         dsel_q       <= dsel_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_cnt_q   <= wrap_cnt_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_cnt   = wrap_cnt_q;

endmodule
